sqrt_arbiter: RTL and testbench

Round-robin scheduler that shares one 8-bit integer square-root engine (inputs Go, N[7:0], reset; outputs answer[3:0], over) among NREQ requesters. It latches a granted operand, runs the engine's Go/over handshake, and returns the 4-bit root to the granted requester. It sits between client blocks and the engine instance; it is the only driver of the engine's Go, N and reset pins.

---
 rtl/sqrt_arbiter.sv | 130 +++++++++++++
 tb/tb_sqrt_arbiter.sv | 235 +++++++++++++++++++++++
 2 files changed

// File: rtl/sqrt_arbiter.sv
// Round-robin front end that shares one 8-bit square-root engine among NREQ requesters.
// Define SQRT_ARB_TIMEOUT_EN to add an engine watchdog that aborts after TIMEOUT ISSUE cycles.
module sqrt_arbiter #(
   parameter int NREQ    = 4,
   parameter int TIMEOUT = 255
) (
   input  logic              clock,
   input  logic              reset,
   input  logic [NREQ-1:0]   req_valid,
   input  logic [8*NREQ-1:0] req_n,
   output logic [NREQ-1:0]   req_ack,
   output logic [NREQ-1:0]   resp_valid,
   output logic [3:0]        resp_root,
   output logic              resp_err,
   output logic              busy,
   output logic              eng_go,
   output logic [7:0]        eng_n,
   output logic              eng_reset,
   input  logic [3:0]        eng_answer,
   input  logic              eng_over
);

   localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;

   localparam logic [1:0] IDLE    = 2'd0;
   localparam logic [1:0] ISSUE   = 2'd1;
   localparam logic [1:0] RELEASE = 2'd2;

   localparam logic [NREQ-1:0] ONE_HOT0 = NREQ'(1);
   localparam logic [PW-1:0]   LAST     = PW'(NREQ - 1);

   logic [1:0]    state;
   logic [PW-1:0] rr_ptr;
   logic [PW-1:0] grant;
   logic [PW-1:0] winner;
   logic          found;
   logic          tmo_hit;

   // First pass covers rr_ptr..NREQ-1, second pass wraps around to 0..rr_ptr-1.
   always_comb begin
      found  = 1'b0;
      winner = '0;
      for (int i = 0; i < NREQ; i++) begin
         if (!found && req_valid[i] && (PW'(i) >= rr_ptr)) begin
            found  = 1'b1;
            winner = PW'(i);
         end
      end
      for (int i = 0; i < NREQ; i++) begin
         if (!found && req_valid[i]) begin
            found  = 1'b1;
            winner = PW'(i);
         end
      end
   end

   assign busy   = (state != IDLE);
   assign eng_go = (state == ISSUE);

   always_ff @(posedge clock) begin
      if (reset) begin
         state      <= IDLE;
         rr_ptr     <= '0;
         grant      <= '0;
         req_ack    <= '0;
         resp_valid <= '0;
         resp_root  <= '0;
         eng_n      <= '0;
      end else begin
         req_ack    <= '0;
         resp_valid <= '0;
         case (state)
            IDLE: begin
               if (found) begin
                  req_ack <= ONE_HOT0 << winner;
                  eng_n   <= req_n[{winner, 3'b000} +: 8];
                  grant   <= winner;
                  rr_ptr  <= (winner == LAST) ? PW'(0) : winner + 1'b1;
                  state   <= ISSUE;
               end
            end
            ISSUE: begin
               if (eng_over) begin
                  resp_valid <= ONE_HOT0 << grant;
                  resp_root  <= eng_answer;
                  state      <= RELEASE;
               end else if (tmo_hit) begin
                  resp_valid <= ONE_HOT0 << grant;
                  resp_root  <= 4'd0;
                  state      <= RELEASE;
               end
            end
            RELEASE: state <= IDLE;
            default: state <= IDLE;
         endcase
      end
   end

`ifdef SQRT_ARB_TIMEOUT_EN
   logic [15:0] tmo_cnt;
   logic        abort_q;
   logic        err_q;

   assign tmo_hit = (state == ISSUE) && !eng_over && (tmo_cnt == 16'(TIMEOUT - 1));

   // Counter sits at zero outside ISSUE, so every job starts its watchdog fresh.
   always_ff @(posedge clock) begin
      if (reset) begin
         tmo_cnt <= '0;
         abort_q <= 1'b0;
         err_q   <= 1'b0;
      end else begin
         tmo_cnt <= (state == ISSUE) ? tmo_cnt + 16'd1 : 16'd0;
         abort_q <= tmo_hit;
         err_q   <= tmo_hit;
      end
   end

   assign resp_err  = err_q;
   assign eng_reset = reset | abort_q;
`else
   logic unused_timeout;

   assign unused_timeout = (TIMEOUT != 0);
   assign tmo_hit        = 1'b0;
   assign resp_err       = 1'b0;
   assign eng_reset      = reset;
`endif

endmodule

// File: tb/tb_sqrt_arbiter.sv
// Self-checking bench for sqrt_arbiter with a behavioural square-root engine stub.
// Round-robin order and roots come from a reference model that uses plain arithmetic.
module tb_sqrt_arbiter;

   localparam int NREQ = 4;

   logic        clock = 1'b0;
   logic        reset;
   logic [3:0]  req_valid;
   logic [31:0] req_n;
   logic [3:0]  req_ack;
   logic [3:0]  resp_valid;
   logic [3:0]  resp_root;
   logic        resp_err;
   logic        busy;
   logic        eng_go;
   logic [7:0]  eng_n;
   logic        eng_reset;
   logic [3:0]  eng_answer;
   logic        eng_over;

   int checks   = 0;
   int failures = 0;
   int m_rr     = 0;
   int eng_lat  = 0;
   int eng_cnt  = 0;
   bit eng_stall = 1'b0;

   sqrt_arbiter #(.NREQ(NREQ), .TIMEOUT(8)) dut (
      .clock      (clock),
      .reset      (reset),
      .req_valid  (req_valid),
      .req_n      (req_n),
      .req_ack    (req_ack),
      .resp_valid (resp_valid),
      .resp_root  (resp_root),
      .resp_err   (resp_err),
      .busy       (busy),
      .eng_go     (eng_go),
      .eng_n      (eng_n),
      .eng_reset  (eng_reset),
      .eng_answer (eng_answer),
      .eng_over   (eng_over)
   );

   always #5 clock = ~clock;

   function automatic int isqrt(input int n);
      int r = 0;
      while ((r + 1) * (r + 1) <= n) r++;
      return r;
   endfunction

   function automatic int pick(input logic [3:0] pend, input int rr);
      for (int k = 0; k < NREQ; k++) begin
         if (pend[(rr + k) % NREQ]) return (rr + k) % NREQ;
      end
      return 0;
   endfunction

   // Engine stub: raises over after eng_lat busy cycles and holds it until Go drops.
   always @(posedge clock) begin
      if (eng_reset) begin
         eng_over   <= 1'b0;
         eng_answer <= 4'd0;
         eng_cnt    <= 0;
      end else if (!eng_go) begin
         eng_over <= 1'b0;
         eng_cnt  <= 0;
      end else if (!eng_over && !eng_stall) begin
         if (eng_cnt >= eng_lat) begin
            eng_over   <= 1'b1;
            eng_answer <= 4'(isqrt(int'(eng_n)));
         end else begin
            eng_cnt <= eng_cnt + 1;
         end
      end
   end

   initial begin
      #400000;
      $display("[TB] FAIL watchdog: got no finish, required completion within time limit");
      $fatal(1, "[TB] watchdog expired");
   end

   task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      assert (got === exp) else begin
         failures++;
         $error("[TB] FAIL %s: got=%0h expected=%0h", tag, got, exp);
      end
   endtask

   // Enters and leaves at a falling edge with the arbiter idle.
   task automatic applyStimulus(input logic [3:0] mask, input logic [31:0] ops,
                                input logic [3:0] late_mask, input logic [31:0] late_ops,
                                input string tag);
      logic [3:0] pending;
      logic [7:0] op;
      int         w;
      int         cyc;
      bit         first;
      pending   = mask;
      first     = 1'b1;
      req_n     = ops;
      req_valid = mask;
      while (pending != 4'd0) begin
         w  = pick(pending, m_rr);
         op = req_n[8*w +: 8];
         @(negedge clock);
         checkOutput({tag, " ack"}, 32'(req_ack), 32'(1 << w));
         checkOutput({tag, " busy"}, 32'(busy), 32'd1);
         req_valid[w] = 1'b0;
         pending[w]   = 1'b0;
         m_rr         = (w + 1) % NREQ;
         if (first) begin
            first = 1'b0;
            for (int i = 0; i < NREQ; i++) begin
               if (late_mask[i]) req_n[8*i +: 8] = late_ops[8*i +: 8];
            end
            req_valid = req_valid | late_mask;
            pending   = pending | late_mask;
         end
         eng_lat = $urandom_range(0, 5);
         cyc = 0;
         while (resp_valid == 4'd0 && cyc < 40) begin
            checkOutput({tag, " go"}, 32'(eng_go), 32'd1);
            checkOutput({tag, " eng_n"}, 32'(eng_n), 32'(op));
            @(negedge clock);
            cyc++;
         end
         checkOutput({tag, " resp_valid"}, 32'(resp_valid), 32'(1 << w));
         checkOutput({tag, " root"}, 32'(resp_root), 32'(isqrt(int'(op))));
         checkOutput({tag, " err"}, 32'(resp_err), 32'd0);
         checkOutput({tag, " go_rel"}, 32'(eng_go), 32'd0);
         @(negedge clock);
         checkOutput({tag, " idle"}, 32'(busy), 32'd0);
         checkOutput({tag, " go_idle"}, 32'(eng_go), 32'd0);
         checkOutput({tag, " no_ack"}, 32'(req_ack), 32'd0);
         checkOutput({tag, " no_resp"}, 32'(resp_valid), 32'd0);
      end
   endtask

   initial begin
      reset     = 1'b1;
      req_valid = 4'd0;
      req_n     = 32'd0;
      repeat (2) @(negedge clock);
      checkOutput("rst busy", 32'(busy), 32'd0);
      checkOutput("rst ack", 32'(req_ack), 32'd0);
      checkOutput("rst resp", 32'(resp_valid), 32'd0);
      checkOutput("rst go", 32'(eng_go), 32'd0);
      checkOutput("rst eng_n", 32'(eng_n), 32'd0);
      checkOutput("rst eng_reset", 32'(eng_reset), 32'd1);
      reset = 1'b0;
      #1;
      checkOutput("rel eng_reset", 32'(eng_reset), 32'd0);
      @(negedge clock);

      // Contention: two full rounds, starting from rr_ptr 0 each time.
      applyStimulus(4'b1111, {8'd81, 8'd49, 8'd25, 8'd9}, 4'd0, 32'd0, "cont1");
      applyStimulus(4'b1111, {8'd144, 8'd100, 8'd64, 8'd36}, 4'd0, 32'd0, "cont2");

      applyStimulus(4'b0001, 32'd200, 4'd0, 32'd0, "single");
      checkOutput("single gap", 32'(eng_go), 32'd0);

      applyStimulus(4'b0010, {8'd0, 8'd0, 8'd1, 8'd0}, 4'd0, 32'd0, "bnd1");
      applyStimulus(4'b0010, {8'd0, 8'd0, 8'd16, 8'd0}, 4'd0, 32'd0, "bnd16");
      applyStimulus(4'b0010, {8'd0, 8'd0, 8'd255, 8'd0}, 4'd0, 32'd0, "bnd255");
      applyStimulus(4'b0010, {8'd0, 8'd0, 8'd0, 8'd0}, 4'd0, 32'd0, "bnd0");

      applyStimulus(4'b0001, {8'd0, 8'd0, 8'd0, 8'd170}, 4'b0100, {8'd0, 8'd121, 8'd0, 8'd0}, "late");

      for (int r = 0; r < 6; r++) begin
         applyStimulus(4'($urandom_range(1, 15)), $urandom, 4'd0, 32'd0, "rand");
      end

      // Abandon a job with reset during ISSUE, then confirm the pointer restarted at 0.
      req_n     = {8'd0, 8'd0, 8'd99, 8'd0};
      req_valid = 4'b0010;
      @(negedge clock);
      eng_lat = 10;
      checkOutput("abort ack", 32'(req_ack), 32'b0010);
      req_valid = 4'd0;
      @(negedge clock);
      checkOutput("abort busy", 32'(busy), 32'd1);
      reset = 1'b1;
      #1;
      checkOutput("abort eng_reset", 32'(eng_reset), 32'd1);
      @(negedge clock);
      reset = 1'b0;
      m_rr  = 0;
      checkOutput("abort resp", 32'(resp_valid), 32'd0);
      checkOutput("abort root", 32'(resp_root), 32'd0);
      checkOutput("abort err", 32'(resp_err), 32'd0);
      checkOutput("abort busy0", 32'(busy), 32'd0);
      checkOutput("abort go", 32'(eng_go), 32'd0);
      checkOutput("abort eng_n", 32'(eng_n), 32'd0);
      checkOutput("abort ack0", 32'(req_ack), 32'd0);
      for (int c = 0; c < 6; c++) begin
         @(negedge clock);
         checkOutput("abort quiet", 32'({resp_valid, busy}), 32'd0);
      end
      applyStimulus(4'b1010, {8'd225, 8'd0, 8'd4, 8'd0}, 4'd0, 32'd0, "post_rst");

`ifdef SQRT_ARB_TIMEOUT_EN
      eng_stall = 1'b1;
      req_n     = {8'd0, 8'd0, 8'd0, 8'd77};
      req_valid = 4'b0001;
      @(negedge clock);
      checkOutput("tmo ack", 32'(req_ack), 32'b0001);
      req_valid = 4'd0;
      m_rr      = 1;
      for (int c = 2; c <= 8; c++) begin
         @(negedge clock);
         checkOutput("tmo wait", 32'({resp_valid, eng_reset, eng_go}), 32'd1);
      end
      @(negedge clock);
      checkOutput("tmo resp", 32'(resp_valid), 32'b0001);
      checkOutput("tmo err", 32'(resp_err), 32'd1);
      checkOutput("tmo root", 32'(resp_root), 32'd0);
      checkOutput("tmo eng_reset", 32'(eng_reset), 32'd1);
      checkOutput("tmo go", 32'(eng_go), 32'd0);
      @(negedge clock);
      checkOutput("tmo eng_reset off", 32'(eng_reset), 32'd0);
      checkOutput("tmo idle", 32'({resp_valid, resp_err, busy}), 32'd0);
      eng_stall = 1'b0;
      applyStimulus(4'b0011, {8'd0, 8'd0, 8'd50, 8'd30}, 4'd0, 32'd0, "tmo_after");
`endif

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
